// File: rtl/proc_control_unit.sv
// proc_control_unit
// Instruction sequencer for the 16-bit multi-cycle processor datapath.
// Loads one instruction into the external IR, decodes it and drives the
// per-step bus-mux select, register/A/G load enables and ALU opcode.
// Each instruction takes 2-4 cycles from fetch to done. The control outputs
// are a combinational decode of the current state and the IR contents.

module proc_control_unit #(
   parameter logic [3:0] DIN_SEL = 4'd8,
   parameter logic [3:0] G_SEL   = 4'd10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [15:0] ir,
   output logic        ir_in,
   output logic [7:0]  r_in,
   output logic        a_in,
   output logic        g_in,
   output logic [3:0]  sel,
   output logic [2:0]  alu_op,
   output logic        done,
   output logic        busy
);

   // FSM state encoding
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_T1    = 3'd2;
   localparam logic [2:0] S_T2    = 3'd3;
   localparam logic [2:0] S_T3    = 3'd4;

   // Instruction opcodes
   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SHR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;

   // ALU operation codes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_MUL = 3'b010;
   localparam logic [2:0] ALU_SHR = 3'b011;
   localparam logic [2:0] ALU_SHL = 3'b100;

   logic [2:0] state_r;
   logic [2:0] next_s;

   logic [2:0] opcode_s;
   logic [2:0] rx_s;
   logic       imm_sel_s;
   logic [3:0] opnd_s;
   logic [3:0] rx_sel_s;
   logic [7:0] rx_onehot_s;
   logic [2:0] next_done_s;

   // Immediate payload bits above rY only matter to the datapath, not here.
   logic       unused_imm_s;

   // Field extraction from the instruction register.
   assign opcode_s     = ir[15:13];
   assign rx_s         = ir[12:10];
   assign imm_sel_s    = ir[9];
   assign opnd_s       = imm_sel_s ? DIN_SEL : {1'b0, ir[2:0]};
   assign rx_sel_s     = {1'b0, rx_s};
   assign rx_onehot_s  = 8'b0000_0001 << rx_s;
   assign unused_imm_s = ^ir[8:3];

   // After the final step, chain straight into the next fetch while run is high.
   assign next_done_s  = run ? S_FETCH : S_IDLE;

   // State register; synchronous reset returns to IDLE and wins over run.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Per-step control decode and next-state selection.
   always_comb begin
      next_s = state_r;
      ir_in  = 1'b0;
      r_in   = 8'h00;
      a_in   = 1'b0;
      g_in   = 1'b0;
      sel    = 4'd0;
      alu_op = ALU_ADD;
      done   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (run) begin
               next_s = S_FETCH;
            end else begin
               next_s = S_IDLE;
            end
         end
         S_FETCH: begin
            ir_in  = 1'b1;
            next_s = S_T1;
         end
         S_T1: begin
            case (opcode_s)
               OP_MV: begin
                  sel    = opnd_s;
                  r_in   = rx_onehot_s;
                  done   = 1'b1;
                  next_s = next_done_s;
               end
               OP_ADD, OP_SUB, OP_MUL: begin
                  // Latch the first operand into A before the ALU step.
                  sel    = rx_sel_s;
                  a_in   = 1'b1;
                  next_s = S_T2;
               end
               OP_SHR: begin
                  sel    = opnd_s;
                  g_in   = 1'b1;
                  alu_op = ALU_SHR;
                  next_s = S_T3;
               end
               OP_SHL: begin
                  sel    = opnd_s;
                  g_in   = 1'b1;
                  alu_op = ALU_SHL;
                  next_s = S_T3;
               end
               default: begin
                  // Reserved opcodes complete immediately with no writes.
                  done   = 1'b1;
                  next_s = next_done_s;
               end
            endcase
         end
         S_T2: begin
            sel    = opnd_s;
            g_in   = 1'b1;
            next_s = S_T3;
            case (opcode_s)
               OP_ADD:  alu_op = ALU_ADD;
               OP_SUB:  alu_op = ALU_SUB;
               OP_MUL:  alu_op = ALU_MUL;
               default: alu_op = ALU_ADD;
            endcase
         end
         S_T3: begin
            // Write the ALU result held in G back to rX.
            sel    = G_SEL;
            r_in   = rx_onehot_s;
            done   = 1'b1;
            next_s = next_done_s;
         end
         default: begin
            next_s = S_IDLE;
         end
      endcase
   end

   assign busy = (state_r != S_IDLE);

endmodule

// File: tb/tb_proc_control_unit.sv
// tb_proc_control_unit
// Directed and randomized stimulus for proc_control_unit. A reference model
// expands each instruction into its expected list of per-cycle control
// vectors; every cycle the DUT outputs are compared with the next vector.

module tb_proc_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [15:0] ir  = 16'h0000;
   logic        ir_in;
   logic [7:0]  r_in;
   logic        a_in;
   logic        g_in;
   logic [3:0]  sel;
   logic [2:0]  alu_op;
   logic        done;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [19:0] exp_q[$];
   logic [15:0] pend_q[$];
   logic [15:0] cur_instr = 16'h0000;
   int          lat = 0;

   always #5 clk = ~clk;

   proc_control_unit dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .ir     (ir),
      .ir_in  (ir_in),
      .r_in   (r_in),
      .a_in   (a_in),
      .g_in   (g_in),
      .sel    (sel),
      .alu_op (alu_op),
      .done   (done),
      .busy   (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t ir=%h)", tag, obs, expv, $time, ir);
      end
   endtask

   // Vector layout: {ir_in, r_in, a_in, g_in, sel, alu_op, done, busy}
   function automatic logic [19:0] vec(input logic i_in, input logic [7:0] r,
                                       input logic a, input logic g,
                                       input logic [3:0] s, input logic [2:0] alu,
                                       input logic d);
      return {i_in, r, a, g, s, alu, d, 1'b1};
   endfunction

   // Cycles from fetch to done inclusive.
   function automatic int exp_lat(input logic [15:0] i);
      int opc;
      opc = int'(i[15:13]);
      if (opc == 0 || opc >= 6) return 2;
      if (opc >= 4) return 3;
      return 4;
   endfunction

   // Expand one instruction into its expected step vectors.
   task automatic plan_instr(input logic [15:0] i);
      logic [2:0] opc;
      logic [3:0] opnd;
      logic [7:0] wr;
      logic [2:0] alu;
      opc  = i[15:13];
      opnd = i[9] ? 4'd8 : {1'b0, i[2:0]};
      wr   = 8'd1 << i[12:10];
      alu  = opc - 3'd1;
      exp_q.push_back(vec(1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0));
      if (opc == 3'd0) begin
         exp_q.push_back(vec(1'b0, wr, 1'b0, 1'b0, opnd, 3'd0, 1'b1));
      end else if (opc <= 3'd3) begin
         exp_q.push_back(vec(1'b0, 8'h00, 1'b1, 1'b0, {1'b0, i[12:10]}, 3'd0, 1'b0));
         exp_q.push_back(vec(1'b0, 8'h00, 1'b0, 1'b1, opnd, alu, 1'b0));
         exp_q.push_back(vec(1'b0, wr, 1'b0, 1'b0, 4'd10, 3'd0, 1'b1));
      end else if (opc <= 3'd5) begin
         exp_q.push_back(vec(1'b0, 8'h00, 1'b0, 1'b1, opnd, alu, 1'b0));
         exp_q.push_back(vec(1'b0, wr, 1'b0, 1'b0, 4'd10, 3'd0, 1'b1));
      end else begin
         exp_q.push_back(vec(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1));
      end
   endtask

   // One clock: compare outputs mid-cycle, then drive run/rst for the next edge.
   task automatic cycle(input logic run_v, input logic rst_v);
      logic [19:0] act;
      logic [19:0] e;
      logic        was_idle;
      logic        ending;
      @(negedge clk);
      act      = {ir_in, r_in, a_in, g_in, sel, alu_op, done, busy};
      was_idle = (exp_q.size() == 0);
      e        = was_idle ? 20'd0 : exp_q[0];
      check("outputs", {12'd0, act}, {12'd0, e});
      check("r_in_onehot0", {31'd0, ($countones(r_in) <= 1)}, 32'd1);
      ending = was_idle || e[1];
      if (!was_idle) begin
         if (e[19]) begin
            ir  = cur_instr;
            lat = 1;
         end else begin
            lat++;
         end
         if (e[1]) check("latency", lat, exp_lat(cur_instr));
         void'(exp_q.pop_front());
      end else begin
         ir = 16'($urandom);
      end
      rst = rst_v;
      run = run_v;
      if (rst_v) begin
         exp_q.delete();
      end else if (ending && run_v) begin
         if (pend_q.size() != 0) cur_instr = pend_q.pop_front();
         else                    cur_instr = 16'($urandom);
         plan_instr(cur_instr);
      end
   endtask

   // Start one instruction from IDLE, run it to completion, then idle a cycle.
   task automatic single(input logic [15:0] i);
      pend_q.push_back(i);
      cycle(1'b1, 1'b0);
      repeat (exp_lat(i)) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);

      // MV R2, R5 and MV R2, imm
      single(16'h0805);
      single(16'h0A05);
      // ADD R3, imm(-1)
      single(16'h2FFF);
      // SHL R7, R1
      single(16'hBC01);

      // MUL then SUB back to back with run held high
      pend_q.push_back(16'h6803);
      pend_q.push_back(16'h4C03);
      repeat (8) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);

      // Reserved opcode
      single(16'hE000);

      // Reset during T2 of an ADD, then restart
      pend_q.push_back(16'h2A01);
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      single(16'h2A01);

      // Randomized run/rst activity over random instructions
      for (int k = 0; k < 800; k++) begin
         cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
      end

      // Drain
      repeat (6) cycle(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
